// File: rtl/mips_pkg.sv
// Shared register-file defaults used by decode, execute and the register file.
// NREGS is always derived from the index width so the two cannot drift apart.
package mips_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/mips_scoreboard.sv
// Per-register pending-write counters with RAW-hazard and overflow detection.
// Produces the decode stall and the busy flag; carries no data.
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [ADDR_W-1:0]     issue_dst,
    input  logic [NRD*ADDR_W-1:0] issue_src,
    input  logic [NRD-1:0]        issue_src_used,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_dst,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy
);
    localparam int NREGS = nregs(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREGS-1:0][CNT_W-1:0] pend;
    logic                        hazard;
    logic                        overflow;
    logic                        accept;
    logic [ADDR_W-1:0]           src;

    // A write-back retiring the last outstanding write releases readers in the same cycle.
    always_comb begin
        hazard = 1'b0;
        src    = '0;
        for (int i = 0; i < NRD; i++) begin
            src = issue_src[i*ADDR_W +: ADDR_W];
            if (issue_src_used[i] && pend[src] != '0 &&
                !(wb_valid && wb_dst == src && pend[src] == CNT_ONE) &&
                !(ZERO_REG && src == '0))
                hazard = 1'b1;
        end
    end

    assign overflow = issue_wr && pend[issue_dst] == CNT_MAX;
    assign stall    = issue_valid && (hazard || overflow);
    assign accept   = issue_valid && !stall;
    assign busy     = |pend;

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            logic tracked, inc, dec;
            tracked = !(ZERO_REG && r == 0);
            inc     = tracked && accept && issue_wr && issue_dst == ADDR_W'(r);
            // Stale write-backs (count already zero after a flush) must not wrap.
            dec     = tracked && wb_valid && wb_dst == ADDR_W'(r) && pend[r] != '0;
            if (reset || flush)
                pend[r] <= '0;
            else if (inc && !dec)
                pend[r] <= pend[r] + CNT_ONE;
            else if (dec && !inc)
                pend[r] <= pend[r] - CNT_ONE;
        end
    end
endmodule

// File: rtl/mips_regfile.sv
// Register file with write-back bypass on every read port; hazard tracking
// lives in the scoreboard so the pipeline only routes issue and write-back buses.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IssueValid,
    input  logic                  IssueWr,
    input  logic [ADDR_W-1:0]     IssueDst,
    input  logic [NRD*ADDR_W-1:0] IssueSrc,
    input  logic [NRD-1:0]        IssueSrcUsed,
    output logic [NRD*DATA_W-1:0] RdData,
    output logic                  Stall,
    input  logic                  WbValid,
    input  logic [ADDR_W-1:0]     WbDst,
    input  logic [DATA_W-1:0]     WbData,
    input  logic                  Flush,
    output logic                  Busy
);
    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge Clk) begin
        if (Reset)
            regs <= '0;
        else if (WbValid && !(ZERO_REG && WbDst == '0))
            regs[WbDst] <= WbData;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] src;
        assign src = IssueSrc[i*ADDR_W +: ADDR_W];
        always_comb begin
            if (ZERO_REG && src == '0)
                RdData[i*DATA_W +: DATA_W] = '0;
            else if (WbValid && WbDst == src)
                RdData[i*DATA_W +: DATA_W] = WbData;
            else
                RdData[i*DATA_W +: DATA_W] = regs[src];
        end
    end

    mips_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NRD     (NRD),
        .ZERO_REG(ZERO_REG),
        .CNT_W   (CNT_W)
    ) u_scoreboard (
        .clk           (Clk),
        .reset         (Reset),
        .issue_valid   (IssueValid),
        .issue_wr      (IssueWr),
        .issue_dst     (IssueDst),
        .issue_src     (IssueSrc),
        .issue_src_used(IssueSrcUsed),
        .wb_valid      (WbValid),
        .wb_dst        (WbDst),
        .flush         (Flush),
        .stall         (Stall),
        .busy          (Busy)
    );
endmodule

// File: tb/tb_mips_regfile.sv
// Directed scenarios followed by random traffic, all checked against a
// register/pending-count model built from the register-file rules.
module tb_mips_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int MAXP   = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              IssueValid = 1'b0, IssueWr = 1'b0;
    logic [ADDR_W-1:0] IssueDst = '0;
    logic [NRD*ADDR_W-1:0] IssueSrc = '0;
    logic [NRD-1:0]    IssueSrcUsed = '0;
    logic [NRD*DATA_W-1:0] RdData;
    logic              Stall, Busy;
    logic              WbValid = 1'b0;
    logic [ADDR_W-1:0] WbDst = '0;
    logic [DATA_W-1:0] WbData = '0;
    logic              Flush = 1'b0;

    mips_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1'b1), .CNT_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .IssueWr(IssueWr),
        .IssueDst(IssueDst), .IssueSrc(IssueSrc), .IssueSrcUsed(IssueSrcUsed),
        .RdData(RdData), .Stall(Stall), .WbValid(WbValid), .WbDst(WbDst),
        .WbData(WbData), .Flush(Flush), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int          m_pend [32];
    logic [31:0] m_regs [32];
    logic        o_stall, o_busy;
    logic [31:0] o_rd0, o_rd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int s, input logic wb, input int wd, input logic [31:0] wdat);
        if (s == 0) return 32'h0;
        if (wb && wd == s) return wdat;
        return m_regs[s];
    endfunction

    // One cycle: drive, compare combinational outputs and Busy against the model, clock, update the model.
    task automatic cyc(input logic iv, input logic iwr, input int dst, input int s0, input int s1,
                       input logic [1:0] used, input logic wb, input int wd, input logic [31:0] wdat,
                       input logic fl, input logic rst);
        logic haz, ovf, e_stall, e_busy;
        int   srcs [2];
        IssueValid = iv; IssueWr = iwr; IssueDst = ADDR_W'(dst);
        IssueSrc = {ADDR_W'(s1), ADDR_W'(s0)}; IssueSrcUsed = used;
        WbValid = wb; WbDst = ADDR_W'(wd); WbData = wdat; Flush = fl; Reset = rst;
        #1;
        srcs[0] = s0; srcs[1] = s1;
        haz = 1'b0;
        for (int i = 0; i < 2; i++)
            if (used[i] && srcs[i] != 0 && m_pend[srcs[i]] > 0 &&
                !(wb && wd == srcs[i] && m_pend[srcs[i]] == 1))
                haz = 1'b1;
        ovf = iwr && m_pend[dst] == MAXP;
        e_stall = iv && (haz || ovf);
        e_busy = 1'b0;
        for (int r = 0; r < 32; r++) if (m_pend[r] != 0) e_busy = 1'b1;
        o_stall = Stall; o_busy = Busy; o_rd0 = RdData[31:0]; o_rd1 = RdData[63:32];
        chk("stall", 64'(Stall), 64'(e_stall));
        chk("busy", 64'(Busy), 64'(e_busy));
        chk("rd0", 64'(RdData[31:0]), 64'(m_read(s0, wb, wd, wdat)));
        chk("rd1", 64'(RdData[63:32]), 64'(m_read(s1, wb, wd, wdat)));
        @(posedge Clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_regs[r] = '0; end
        end else begin
            if (wb && wd != 0) m_regs[wd] = wdat;
            if (fl) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 0;
            end else begin
                int before_wb;
                before_wb = m_pend[wd];
                if (iv && !e_stall && iwr && dst != 0) m_pend[dst]++;
                if (wb && wd != 0 && before_wb > 0) m_pend[wd]--;
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, '0, 0, 0);
    endtask
    task automatic issue_wr(input int d);
        cyc(1, 1, d, 0, 0, 2'b00, 0, 0, '0, 0, 0);
    endtask
    task automatic wb_only(input int d, input logic [31:0] v);
        cyc(0, 0, 0, d, 0, 2'b01, 1, d, v, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_pend[r] = 1; m_regs[r] = 32'hxxxx_xxxx; end
        // Reset: model starts cleared after the reset edge; first cycle outputs are not compared.
        IssueValid = 0; Reset = 1;
        @(posedge Clk); #1;
        for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_regs[r] = '0; end
        cyc(0, 0, 0, 5, 0, 2'b11, 0, 0, '0, 0, 1);
        idle();
        chk("reset_busy", 64'(o_busy), 64'(0));
        chk("reset_rd", 64'(o_rd0), 64'(0));

        // Write-back bypass then array read, and r0 stays zero.
        cyc(0, 0, 0, 5, 5, 2'b11, 1, 5, 32'hDEADBEEF, 0, 0);
        chk("bypass_r5_p0", 64'(o_rd0), 64'hDEADBEEF);
        chk("bypass_r5_p1", 64'(o_rd1), 64'hDEADBEEF);
        cyc(0, 0, 0, 5, 0, 2'b11, 0, 0, '0, 0, 0);
        chk("array_r5", 64'(o_rd0), 64'hDEADBEEF);
        chk("r0_zero", 64'(o_rd1), 64'(0));
        cyc(0, 0, 0, 0, 0, 2'b00, 1, 0, 32'h1234, 0, 0);
        cyc(0, 0, 0, 0, 0, 2'b11, 0, 0, '0, 0, 0);
        chk("r0_not_written", 64'(o_rd0), 64'(0));

        // RAW hazard, released by a same-cycle write-back.
        issue_wr(3);
        cyc(1, 0, 0, 3, 1, 2'b01, 0, 0, '0, 0, 0);
        chk("raw_stall", 64'(o_stall), 64'(1));
        cyc(1, 0, 0, 3, 1, 2'b01, 1, 3, 32'h12, 0, 0);
        chk("raw_release", 64'(o_stall), 64'(0));
        chk("raw_bypass", 64'(o_rd0), 64'h12);

        // Pending-count overflow ignores a same-cycle write-back.
        issue_wr(7); issue_wr(7); issue_wr(7);
        cyc(1, 1, 7, 0, 0, 2'b00, 1, 7, 32'h70, 0, 0);
        chk("ovf_stall", 64'(o_stall), 64'(1));
        issue_wr(7);
        chk("ovf_accept", 64'(o_stall), 64'(0));
        wb_only(7, 32'h71); wb_only(7, 32'h72); wb_only(7, 32'h73);
        idle();
        chk("r7_drained", 64'(o_busy), 64'(0));

        // Same-cycle increment and decrement leave the count at one.
        issue_wr(9);
        cyc(1, 1, 9, 0, 0, 2'b00, 1, 9, 32'h90, 0, 0);
        idle();
        chk("r9_busy", 64'(o_busy), 64'(1));
        cyc(1, 0, 0, 9, 0, 2'b01, 0, 0, '0, 0, 0);
        chk("r9_pending", 64'(o_stall), 64'(1));
        wb_only(9, 32'h91);

        // Flush overrides counters but not the array write.
        issue_wr(4); issue_wr(4); issue_wr(6);
        cyc(0, 0, 0, 0, 0, 2'b00, 1, 4, 32'h55, 1, 0);
        cyc(1, 0, 0, 4, 6, 2'b11, 0, 0, '0, 0, 0);
        chk("flush_busy", 64'(o_busy), 64'(0));
        chk("flush_r4", 64'(o_rd0), 64'h55);
        chk("flush_nostall", 64'(o_stall), 64'(0));
        wb_only(6, 32'h66);
        cyc(1, 0, 0, 6, 0, 2'b01, 0, 0, '0, 0, 0);
        chk("stale_wb_busy", 64'(o_busy), 64'(0));
        chk("stale_wb_r6", 64'(o_rd0), 64'h66);

        // Mid-stream reset.
        wb_only(2, 32'h99);
        issue_wr(2); issue_wr(2);
        cyc(1, 1, 2, 2, 0, 2'b01, 1, 2, 32'hAA, 1, 1);
        cyc(1, 0, 0, 2, 0, 2'b01, 0, 0, '0, 0, 0);
        chk("rst_r2", 64'(o_rd0), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_nostall", 64'(o_stall), 64'(0));

        // Random traffic; write-backs target registers that actually have writes outstanding.
        for (int n = 0; n < 400; n++) begin
            int   cand [$];
            int   wd;
            logic wb;
            for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
            wb = cand.size() > 0 && $urandom_range(1, 0) == 1;
            wd = wb ? cand[$urandom_range(cand.size() - 1, 0)] : int'($urandom_range(7, 0));
            cyc(1'($urandom_range(3, 0) != 0), 1'($urandom), int'($urandom_range(7, 0)),
                int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 2'($urandom),
                wb, wd, $urandom, $urandom_range(39, 0) == 0, $urandom_range(99, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_regfile.md
# mips_regfile

Parametrised register file with write-back bypass and a per-register pending-write scoreboard, successor to the fixed 32x32, 2-read-port CPU register array. It sits between decode and the write-back stage, supplies operands for any number of read ports, and raises `Stall` on read-after-write hazards and on pending-count overflow. It also drives the decode-stage stall. Issue bookkeeping and register storage are combined so the pipeline top only routes issue and write-back buses.

## Interface
- `DATA_W`, 32, register width.
- `ADDR_W`, 5, register index width; `NREGS = 2**ADDR_W`.
- `NRD`, 2, number of read/source ports.
- `ZERO_REG`, 1, when 1, register 0 reads as 0 and is never written or tracked.
- `CNT_W`, 2, pending-counter width; max in-flight writes per register = `2**CNT_W-1`.

Ports:
- `Clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `IssueValid`  in  1  decode presents an instruction.
- `IssueWr`  in  1  instruction writes `IssueDst`.
- `IssueDst`  in  `ADDR_W`  destination register.
- `IssueSrc`  in  `NRD*ADDR_W`  source indices; port i at `[i*ADDR_W +: ADDR_W]`.
- `IssueSrcUsed`  in  `NRD`  per-port: source actually read.
- `RdData`  out  `NRD*DATA_W`  operand values, same packing.
- `Stall`  out  1  issue refused this cycle.
- `WbValid`  in  1  write-back strobe.
- `WbDst`  in  `ADDR_W`  write-back register.
- `WbData`  in  `DATA_W`  write-back value.
- `Flush`  in  1  discard all in-flight writes from scoreboard.
- `Busy`  out  1  any pending counter non-zero.

## Operation
- Reads are combinational.
  - `RdData[i]` = 0 if `ZERO_REG` and src is 0.
  - Otherwise `WbData` if `WbValid` and `WbDst` equals src (bypass).
  - Otherwise the array value.
- Write: on `WbValid`, array entry `WbDst` takes `WbData` at the next edge. Writes to reg 0 are dropped when `ZERO_REG`=1.
- Pending counters `pend[r]`, one per register. A counter is "cleared this cycle" when `WbValid`, `WbDst`==r and `pend[r]`==1.
- Hazard on port i: `IssueSrcUsed[i]`, `pend[src]`!=0, and not cleared this cycle. Sources equal to 0 never hazard when `ZERO_REG`=1.
- Overflow: `IssueWr` and `pend[IssueDst]` equals max, ignoring a same-cycle `WbValid` to the same register.
- `Stall` = `IssueValid` & (any hazard | overflow). It is purely combinational; no state depends on it except acceptance.
- Accept = `IssueValid` & !`Stall`.
  - Accept with `IssueWr` to a tracked dst increments `pend[IssueDst]`.
  - `WbValid` to a tracked dst decrements `pend[WbDst]`, saturating at 0 (stale write-back after flush).
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
- `Flush` zeroes all counters at the next edge, overriding same-cycle increments and decrements. The array write from a same-cycle `WbValid` still occurs. `Stall` is still computed from pre-flush counters.
- `Busy` = OR of all counters (registered state only).

## Timing
- Read latency 0; a write-back value is visible via bypass in the same cycle and from the array the next cycle.
- Scoreboard update latency 1: a counter changed at edge N affects `Stall` from cycle N onward.
- Reset (any cycle, including mid-stream): all array entries 0 and all counters 0 at the edge.
  - After reset: `Busy`=0, `RdData`=0 unless bypassed, `Stall`=0.
  - Reset overrides `WbValid`, issue and `Flush` in that cycle.
- No ready/valid back-pressure on write-back: it is always accepted.

## Structure
- Shared package `mips_pkg` holds `DATA_W`/`ADDR_W` defaults and the `NREGS` derivation, shared with decode and execute.
- Sub-module `mips_scoreboard` holds counters, hazard/overflow logic, `Stall` and `Busy`. It has no data path.
- Top `mips_regfile` holds the array, bypass mux per port, and instantiates `mips_scoreboard`.

## Test plan
- Reset, then write-back r5=0xDEADBEEF; read r5 on both ports the same cycle and the next -> 0xDEADBEEF both cycles; read r0 -> 0.
- Issue r3 write (pend=1); next cycle issue reading r3 -> `Stall`=1. Then `WbValid` r3=0x12 -> `Stall`=0 the same cycle, `RdData`=0x12 via bypass, accepted.
- Issue three writes to r7 with `CNT_W`=2 (pend=3); fourth write to r7 -> `Stall`=1 even with same-cycle WB to r7. After that WB, next cycle accepted.
- Issue + WB to r9 in the same cycle with pend[r9]=1 -> pend stays 1, `Busy`=1.
- pend r4=2, r6=1; assert `Flush` with WB r4=0x55 -> next cycle `Busy`=0 and r4 holds 0x55. A later stale WB r6 leaves pend[r6]=0.
- Assert `Reset` mid-stream with pend r2=2 and r2=0x99 -> next cycle r2 reads 0, `Busy`=0, and reading r2 does not stall.
